// File: rtl/resp_uart_tx.sv
// UART 8N1 transmitter for one SZ_WORD-bit PUF response word, sent MSB byte first.
// A word is captured on a one-cycle load pulse; loads that arrive mid-frame are flagged, not taken.
module resp_uart_tx #(
    parameter int SZ_WORD      = 264,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SZ_WORD-1:0] data_in,
    output logic               tx,
    output logic               busy,
    output logic               done,
    output logic               overrun
);
    localparam int NBYTES = SZ_WORD / 8;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [SZ_WORD-1:0] shreg, shreg_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [2:0]         bit_cnt, bit_next;
    logic [BYTE_W-1:0]  byte_cnt, byte_next;
    logic               tx_next, busy_next, done_next, overrun_next;
    logic [7:0]         cur_byte;
    logic               bit_end;

    // The byte on the wire is always the top byte; STOP shifts the next one up.
    assign cur_byte = shreg[SZ_WORD-1 -: 8];
    assign bit_end  = (baud_cnt == BAUD_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next   = state;
        shreg_next   = shreg;
        baud_next    = baud_cnt;
        bit_next     = bit_cnt;
        byte_next    = byte_cnt;
        tx_next      = tx;
        busy_next    = busy;
        done_next    = 1'b0;
        overrun_next = load & busy;

        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (load) begin
                    shreg_next = data_in;
                    baud_next  = '0;
                    bit_next   = '0;
                    byte_next  = '0;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = cur_byte[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                        tx_next  = cur_byte[bit_cnt + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shreg_next = shreg << 8;
                    if (byte_cnt == BYTE_LAST) begin
                        byte_next  = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        byte_next  = byte_cnt + BYTE_W'(1);
                        tx_next    = 1'b0;
                        state_next = START;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the shift register is plain flops, not a RAM, so clearing it on reset is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state    <= state_next;
            shreg    <= shreg_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            byte_cnt <= byte_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
            overrun  <= overrun_next;
        end
    end
endmodule

// File: tb/tb_resp_uart_tx.sv
// Self-checking bench for resp_uart_tx: a 2-byte instance for table vectors and corner cases,
// a 33-byte instance for the full-width ramp, random words, and mid-frame reset.
module tb_resp_uart_tx;
    localparam int CB   = 4;
    localparam int NB_S = 2;
    localparam int NB_L = 33;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_s, load_l;
    logic [15:0]  data_s;
    logic [263:0] data_l;
    logic         tx_s, busy_s, done_s, ov_s;
    logic         tx_l, busy_l, done_l, ov_l;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_b [0:NB_L-1];

    typedef struct {
        logic [15:0] data;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          ov_pos;
    } vec_t;
    vec_t tbl [5];

    resp_uart_tx #(.SZ_WORD(16), .CLKS_PER_BIT(CB)) dut_s (
        .clk(clk), .rst(rst), .load(load_s), .data_in(data_s),
        .tx(tx_s), .busy(busy_s), .done(done_s), .overrun(ov_s)
    );

    resp_uart_tx #(.SZ_WORD(264), .CLKS_PER_BIT(CB)) dut_l (
        .clk(clk), .rst(rst), .load(load_l), .data_in(data_l),
        .tx(tx_l), .busy(busy_l), .done(done_l), .overrun(ov_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [263:0] rand_word();
        logic [263:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w = {w[231:0], 32'($urandom)};
        return w;
    endfunction

    // Reference: byte i on the wire is byte (nb-1-i) of the word, counting from the LSB end.
    task automatic set_exp(input logic [263:0] w, input int nb);
        for (int i = 0; i < nb; i++) exp_b[i] = w[(nb-1-i)*8 +: 8];
    endtask

    task automatic drive_load(input bit sel, input logic [263:0] w);
        if (sel) begin
            load_l = 1'b1;
            data_l = w;
            load_s = 1'b0;
        end else begin
            load_s = 1'b1;
            data_s = w[15:0];
            load_l = 1'b0;
        end
    endtask

    task automatic start(input bit sel, input logic [263:0] w);
        @(negedge clk);
        drive_load(sel, w);
    endtask

    task automatic idle_check(input bit sel, input int n, input string name);
        int err;
        err = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel ? (tx_l !== 1'b1 || busy_l !== 1'b0 || done_l !== 1'b0 || ov_l !== 1'b0)
                    : (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0 || ov_s !== 1'b0))
                err++;
        end
        check(name, err, 0);
    endtask

    // Checks one frame whose load was driven at the previous negedge. Sample j is taken
    // j cycles after the first tx=0 cycle; sample nb*10*CB is the done cycle.
    task automatic frame(input bit sel, input int nb, input int ov_pos, input bit chain,
                         input logic [263:0] nxt, input int abort_at, input string name);
        int   len, e_tx, e_busy, e_done, e_ov, n_busy, n_done, bi, ferr;
        bit   prev_load, aborted;
        logic t, b, d, o, et;
        logic [7:0] rb;
        logic txs [$];
        len = nb * 10 * CB;
        e_tx = 0; e_busy = 0; e_done = 0; e_ov = 0; n_busy = 0; n_done = 0;
        prev_load = 1'b0;
        aborted   = 1'b0;
        for (int j = 0; j <= len; j++) begin
            @(negedge clk);
            t = sel ? tx_l : tx_s;
            b = sel ? busy_l : busy_s;
            d = sel ? done_l : done_s;
            o = sel ? ov_l : ov_s;
            if (j < len) begin
                bi = j / CB;
                if (bi % 10 == 0)      et = 1'b0;
                else if (bi % 10 == 9) et = 1'b1;
                else                   et = exp_b[bi / 10][bi % 10 - 1];
            end else begin
                et = 1'b1;
            end
            if (t !== et)               e_tx++;
            if (b !== (j < len))        e_busy++;
            if (d !== (j == len))       e_done++;
            if (o !== prev_load)        e_ov++;
            if (b === 1'b1)             n_busy++;
            if (d === 1'b1)             n_done++;
            txs.push_back(t);
            if (j == abort_at) begin
                rst = 1'b1;
                #1;
                check({name, " async tx"},   sel ? tx_l : tx_s, 1);
                check({name, " async busy"}, sel ? busy_l : busy_s, 0);
                aborted = 1'b1;
                break;
            end
            prev_load = 1'b0;
            load_s    = 1'b0;
            load_l    = 1'b0;
            if (j == ov_pos) begin
                prev_load = 1'b1;
                drive_load(sel, rand_word());
            end else if (j == len && chain) begin
                drive_load(sel, nxt);
            end
        end
        check({name, " tx waveform errors"}, e_tx, 0);
        check({name, " busy errors"}, e_busy, 0);
        check({name, " done errors"}, e_done, 0);
        check({name, " overrun errors"}, e_ov, 0);
        if (aborted) return;
        check({name, " busy cycles"}, n_busy, len);
        check({name, " done pulses"}, n_done, 1);
        ferr = 0;
        for (int i = 0; i < nb; i++) begin
            rb = '0;
            for (int k = 0; k < 8; k++) rb[k] = txs[(i*10 + 1 + k)*CB + CB/2];
            if (txs[(i*10)*CB + CB/2] !== 1'b0 || txs[(i*10 + 9)*CB + CB/2] !== 1'b1) ferr++;
            check($sformatf("%s byte%0d", name, i), rb, exp_b[i]);
        end
        check({name, " framing errors"}, ferr, 0);
    endtask

    initial begin
        logic [263:0] w, nxt;
        bit           pending, chain;
        int           err, ov;

        tbl[0] = '{data: 16'hA53C, b0: 8'hA5, b1: 8'h3C, ov_pos: -1};
        tbl[1] = '{data: 16'h0000, b0: 8'h00, b1: 8'h00, ov_pos: -1};
        tbl[2] = '{data: 16'hFFFF, b0: 8'hFF, b1: 8'hFF, ov_pos: -1};
        tbl[3] = '{data: 16'h8001, b0: 8'h80, b1: 8'h01, ov_pos: 10};
        tbl[4] = '{data: 16'h1E69, b0: 8'h1E, b1: 8'h69, ov_pos: NB_S*10*CB - 1};

        rst = 1'b1; load_s = 1'b0; load_l = 1'b0; data_s = '0; data_l = '0;

        err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0 || ov_s !== 1'b0) err++;
            if (tx_l !== 1'b1 || busy_l !== 1'b0 || done_l !== 1'b0 || ov_l !== 1'b0) err++;
            load_s = 1'($urandom);
            load_l = 1'($urandom);
            data_s = 16'($urandom);
            data_l = rand_word();
        end
        check("reset hold outputs", err, 0);
        @(negedge clk);
        rst = 1'b0; load_s = 1'b0; load_l = 1'b0;
        idle_check(0, 4, "post-reset idle small");
        idle_check(1, 1, "post-reset idle large");

        for (int v = 0; v < 5; v++) begin
            exp_b[0] = tbl[v].b0;
            exp_b[1] = tbl[v].b1;
            start(0, {248'b0, tbl[v].data});
            frame(0, NB_S, tbl[v].ov_pos, 1'b0, '0, -1, $sformatf("vec%0d", v));
            idle_check(0, 3, $sformatf("vec%0d idle after", v));
        end

        set_exp({248'b0, 16'hC35A}, NB_S);
        start(0, {248'b0, 16'hC35A});
        frame(0, NB_S, -1, 1'b1, {248'b0, 16'h0FF0}, -1, "b2b first");
        set_exp({248'b0, 16'h0FF0}, NB_S);
        frame(0, NB_S, -1, 1'b0, '0, -1, "b2b second");
        idle_check(0, 3, "b2b idle after");

        for (int i = 0; i < NB_L; i++) w[(NB_L-1-i)*8 +: 8] = 8'(i);
        set_exp(w, NB_L);
        start(1, w);
        frame(1, NB_L, -1, 1'b0, '0, -1, "ramp");
        idle_check(1, 3, "ramp idle after");

        pending = 1'b0;
        nxt     = '0;
        for (int r = 0; r < 5; r++) begin
            if (!pending) begin
                w = rand_word();
                set_exp(w, NB_L);
                start(1, w);
            end else begin
                set_exp(nxt, NB_L);
            end
            ov    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB_L*10*CB - 1)) : -1;
            chain = (r < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            nxt   = rand_word();
            frame(1, NB_L, ov, chain, nxt, -1, $sformatf("rand%0d", r));
            pending = chain;
            if (!chain) idle_check(1, 2, $sformatf("rand%0d idle after", r));
        end

        set_exp(w, NB_L);
        for (int i = 0; i < NB_L; i++) exp_b[i] = 8'(i);
        for (int i = 0; i < NB_L; i++) w[(NB_L-1-i)*8 +: 8] = 8'(i);
        start(1, w);
        frame(1, NB_L, -1, 1'b0, '0, 5*10*CB + 10, "midrst");
        @(negedge clk);
        rst = 1'b0;
        idle_check(1, 3, "midrst idle after release");
        w = rand_word();
        set_exp(w, NB_L);
        start(1, w);
        frame(1, NB_L, -1, 1'b0, '0, -1, "after midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
